// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a block RAM with separate read/write ports.
// Dual-issues a read and a write per cycle when they do not collide; otherwise round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              idle
);

  logic [1:0]             v, we, rdy, w_acc, r_acc;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic                   prio, conflict, w_idx, r_idx;
  logic [2:1]             rd_vld, rd_tag;
  logic [1:0]             rsp_vld;
  logic [1:0][DATA_W-1:0] rsp_dat;

  assign v     = {req1_valid, req0_valid};
  assign we    = {req1_we, req0_we};
  assign addr  = {req1_addr, req0_addr};
  assign wdata = {req1_wdata, req0_wdata};

  // Same-type pairs or a read/write pair on one address cannot share a cycle.
  assign conflict = (&v) & ((we[0] == we[1]) | (addr[0] == addr[1]));

  assign rdy[0] = v[0] & (~conflict | ~prio);
  assign rdy[1] = v[1] & (~conflict |  prio);
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  assign w_acc = rdy & we;
  assign r_acc = rdy & ~we;
  assign w_idx = w_acc[1];
  assign r_idx = r_acc[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_r_addr <= '0;
      rd_vld     <= '0;
      rd_tag     <= '0;
    end else begin
      if (conflict) prio <= ~prio;
      mem_w_en <= |w_acc;
      if (|w_acc) begin
        mem_w_addr <= addr[w_idx];
        mem_w_data <= wdata[w_idx];
      end
      rd_vld <= {rd_vld[1], |r_acc};
      if (|r_acc) begin
        mem_r_addr <= addr[r_idx];
        rd_tag[1]  <= r_idx;
      end
      rd_tag[2] <= rd_tag[1];
    end
  end

  assign mem_r_en = rd_vld[1];

  // Stage 2 tag lines up with the RAM's registered read data.
  for (genvar k = 0; k < 2; k++) begin : g_rsp
    assign rsp_vld[k] = rd_vld[2] & (rd_tag[2] == k[0]);
    assign rsp_dat[k] = rsp_vld[k] ? mem_r_data : '0;
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_dat[0];
  assign rsp1_data  = rsp_dat[1];

  assign idle = ~(|v) & ~mem_w_en & ~rd_vld[1] & ~rd_vld[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read RAM model attached.
module tb_mem_arbiter;
  logic       clk = 0, rst_n = 0;
  logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       mem_w_en, mem_r_en, idle;
  logic [7:0] mem_w_addr, mem_w_data, mem_r_addr;
  logic [7:0] mem_r_data = 0;
  logic [7:0] ram [256];
  int         n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .idle(idle)
  );

  initial for (int i = 0; i < 256; i++) ram[i] = ~i[7:0];

  always @(posedge clk) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram[mem_r_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the start of the next cycle (inputs change just after posedge).
  task automatic next;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v0, w0, input logic [7:0] a0, d0,
                       input logic v1, w1, input logic [7:0] a1, d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic chk_outs_zero(input string tag);
    check({tag, "_wen"}, mem_w_en, 0);
    check({tag, "_ren"}, mem_r_en, 0);
    check({tag, "_waddr"}, mem_w_addr, 0);
    check({tag, "_wdata"}, mem_w_data, 0);
    check({tag, "_raddr"}, mem_r_addr, 0);
    check({tag, "_rv0"}, rsp0_valid, 0);
    check({tag, "_rv1"}, rsp1_valid, 0);
    check({tag, "_rd0"}, rsp0_data, 0);
    check({tag, "_rd1"}, rsp1_data, 0);
    check({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    #12;
    chk_outs_zero("rst");
    next; rst_n = 1;
    next;

    // Write then read-back through the pipeline.
    drive(1, 1, 8'h03, 8'h5A, 0, 0, 0, 0);
    #1 check("t1_rdy_w", req0_ready, 1);
    check("t1_idle_busy", idle, 0);
    next; drive(1, 0, 8'h03, 0, 0, 0, 0, 0);
    #1 check("t1_rdy_r", req0_ready, 1);
    check("t1_wen", mem_w_en, 1);
    check("t1_waddr", mem_w_addr, 8'h03);
    check("t1_wdata", mem_w_data, 8'h5A);
    next; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t1_wen_off", mem_w_en, 0);
    check("t1_ren", mem_r_en, 1);
    check("t1_raddr", mem_r_addr, 8'h03);
    check("t1_rv0_early", rsp0_valid, 0);
    next;
    #1 check("t1_rv0", rsp0_valid, 1);
    check("t1_rd0", rsp0_data, 8'h5A);
    check("t1_rv1", rsp1_valid, 0);
    next;
    #1 check("t1_rv0_off", rsp0_valid, 0);
    check("t1_idle", idle, 1);

    // Both read continuously: grants alternate starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 8'h10, 0, 1, 0, 8'h20, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (i < 4) begin
        check($sformatf("t2_rdy0_%0d", i), req0_ready, (i % 2) == 0);
        check($sformatf("t2_rdy1_%0d", i), req1_ready, (i % 2) == 1);
      end
      if (i >= 2) begin
        check($sformatf("t2_rv0_%0d", i), rsp0_valid, (i % 2) == 0);
        check($sformatf("t2_rv1_%0d", i), rsp1_valid, (i % 2) == 1);
        check($sformatf("t2_rd0_%0d", i), rsp0_data, (i % 2) == 0 ? 8'hEF : 8'h00);
        check($sformatf("t2_rd1_%0d", i), rsp1_data, (i % 2) == 1 ? 8'hDF : 8'h00);
      end
      next;
    end

    // Dual issue: write 0x07 from req0, read 0x08 from req1.
    drive(1, 1, 8'h07, 8'h11, 1, 0, 8'h08, 0);
    #1 check("t3_rdy0", req0_ready, 1);
    check("t3_rdy1", req1_ready, 1);
    next; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t3_wen", mem_w_en, 1);
    check("t3_ren", mem_r_en, 1);
    check("t3_waddr", mem_w_addr, 8'h07);
    check("t3_wdata", mem_w_data, 8'h11);
    check("t3_raddr", mem_r_addr, 8'h08);
    next;
    #1 check("t3_rv1", rsp1_valid, 1);
    check("t3_rd1", rsp1_data, 8'hF7);
    check("t3_rv0", rsp0_valid, 0);
    next;

    // Write/write contention moves prio to requester 1.
    drive(1, 1, 8'h30, 8'h01, 1, 1, 8'h31, 8'h02);
    #1 check("t4_ww_rdy0", req0_ready, 1);
    check("t4_ww_rdy1", req1_ready, 0);
    next; drive(0, 0, 0, 0, 1, 1, 8'h31, 8'h02);
    #1 check("t4_w1_rdy1", req1_ready, 1);
    next;

    // Same-address collision with prio=1: read first sees old data.
    drive(1, 1, 8'h04, 8'hAA, 1, 0, 8'h04, 0);
    #1 check("t4_c_rdy0", req0_ready, 0);
    check("t4_c_rdy1", req1_ready, 1);
    next; drive(1, 1, 8'h04, 8'hAA, 0, 0, 0, 0);
    #1 check("t4_c2_rdy0", req0_ready, 1);
    check("t4_c2_ren", mem_r_en, 1);
    check("t4_c2_wen", mem_w_en, 0);
    next; drive(1, 0, 8'h04, 0, 1, 0, 8'h10, 0);
    #1 check("t4_c3_wen", mem_w_en, 1);
    check("t4_c3_wdata", mem_w_data, 8'hAA);
    check("t4_c3_rv1", rsp1_valid, 1);
    check("t4_c3_rd1", rsp1_data, 8'hFB);
    check("t4_prio0_rdy0", req0_ready, 1);
    check("t4_prio0_rdy1", req1_ready, 0);
    next; drive(0, 0, 0, 0, 1, 0, 8'h10, 0);
    #1 check("t4_c4_rdy1", req1_ready, 1);
    next; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t4_new_rv0", rsp0_valid, 1);
    check("t4_new_rd0", rsp0_data, 8'hAA);
    next;
    #1 check("t4_c6_rv1", rsp1_valid, 1);
    check("t4_c6_rd1", rsp1_data, 8'hEF);
    next;

    // Reset while a read is in flight drops it.
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
    #1 check("t5_rdy0", req0_ready, 1);
    next; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t5_ren", mem_r_en, 1);
    rst_n = 0;
    #1 chk_outs_zero("t5_rst");
    next; next; rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t5_norsp0_%0d", i), rsp0_valid, 0);
      check($sformatf("t5_norsp1_%0d", i), rsp1_valid, 0);
      check($sformatf("t5_idle_%0d", i), idle, 1);
      next;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
